// File: rtl/motor_drive.sv
// Dual-channel H-bridge motor driver.
// Two independent OFF/RUN/DEAD channel FSMs share one free-running PWM
// counter and a period-synchronous duty register. A direction reversal
// always passes through DEAD, which holds both bridge legs off for exactly
// DEAD_CYCLES cycles. A stop command turns the bridge off with no dead time.
// All outputs are registered, so each is a pure function of the current state.
module motor_drive #(
   parameter int unsigned DEAD_CYCLES = 1000,  // legal range 1..65535
   parameter int unsigned PWM_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       motorIn,
   input  logic [1:0]       motorEn,
   input  logic [PWM_W-1:0] duty,
   output logic [3:0]       hb_in,
   output logic [1:0]       hb_en,
   output logic [1:0]       dead
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'b00,
      ST_RUN  = 2'b01,
      ST_DEAD = 2'b10
   } state_t;

   // Complete state of one bridge channel.
   typedef struct packed {
      state_t      st;
      logic [1:0]  dir;   // latched direction, only meaningful in RUN
      logic [15:0] dcnt;  // dead-time cycles remaining after this one
   } ch_t;

   localparam logic [1:0]       DIR_A     = 2'b10;
   localparam logic [1:0]       DIR_B     = 2'b01;
   localparam logic [1:0]       DIR_NONE  = 2'b00;
   localparam logic [15:0]      DEAD_LOAD = 16'(DEAD_CYCLES - 32'd1);
   localparam logic [PWM_W-1:0] CNT_MAX   = {PWM_W{1'b1}};
   localparam logic [PWM_W-1:0] CNT_ONE   = PWM_W'(1);
   localparam ch_t              CH_RESET  = '{st: ST_OFF, dir: DIR_NONE, dcnt: 16'd0};

   // A pair is a drive command only when enabled and exactly one leg is requested.
   function automatic logic cmd_valid(input logic en, input logic [1:0] pair);
      return en && ((pair == DIR_A) || (pair == DIR_B));
   endfunction

   // Bridge leg drive for a channel; anything but a clean direction is forced off,
   // so 2'b11 can never reach the bridge.
   function automatic logic [1:0] leg_drive(input ch_t ch);
      logic [1:0] pair;
      if ((ch.st == ST_RUN) && ((ch.dir == DIR_A) || (ch.dir == DIR_B))) begin
         pair = ch.dir;
      end else begin
         pair = DIR_NONE;
      end
      return pair;
   endfunction

   // One channel's next state from its current state and this cycle's command.
   function automatic ch_t ch_next(input ch_t cur, input logic valid, input logic [1:0] cmd);
      ch_t nxt;
      nxt = cur;
      case (cur.st)
         ST_OFF: begin
            if (valid) begin
               nxt.st  = ST_RUN;
               nxt.dir = cmd;
            end else begin
               nxt.dir = DIR_NONE;
            end
         end
         ST_RUN: begin
            if (!valid) begin
               // Stop needs no dead time: the bridge simply goes off.
               nxt.st  = ST_OFF;
               nxt.dir = DIR_NONE;
            end else if (cmd != cur.dir) begin
               // Reversal: both legs off for the whole dead interval first.
               nxt.st   = ST_DEAD;
               nxt.dir  = DIR_NONE;
               nxt.dcnt = DEAD_LOAD;
            end else begin
               nxt.st = ST_RUN;
            end
         end
         ST_DEAD: begin
            // Inputs are ignored until the interval has fully elapsed.
            if (cur.dcnt == 16'd0) begin
               if (valid) begin
                  nxt.st  = ST_RUN;
                  nxt.dir = cmd;
               end else begin
                  nxt.st  = ST_OFF;
                  nxt.dir = DIR_NONE;
               end
            end else begin
               nxt.dcnt = cur.dcnt - 16'd1;
            end
         end
         default: begin
            nxt = CH_RESET;
         end
      endcase
      return nxt;
   endfunction

   logic [PWM_W-1:0] pwm_cnt_r;
   logic [PWM_W-1:0] duty_q_r;
   logic [PWM_W-1:0] pwm_cnt_nxt_s;
   logic [PWM_W-1:0] duty_q_nxt_s;
   logic             pwm_on_nxt_s;

   ch_t              ch0_r;
   ch_t              ch1_r;
   ch_t              ch0_nxt_s;
   ch_t              ch1_nxt_s;

   logic [3:0]       hb_in_r;
   logic [1:0]       hb_en_r;
   logic [1:0]       dead_r;
   logic [3:0]       hb_in_nxt_s;
   logic [1:0]       hb_en_nxt_s;
   logic [1:0]       dead_nxt_s;

   // PWM next values; duty is only taken at the period boundary so a period is never cut short.
   always_comb begin
      pwm_cnt_nxt_s = pwm_cnt_r + CNT_ONE;
      if (pwm_cnt_r == CNT_MAX) begin
         duty_q_nxt_s = duty;
      end else begin
         duty_q_nxt_s = duty_q_r;
      end
      // Evaluated on next-cycle values so the registered enable lines up with the counter.
      pwm_on_nxt_s = (pwm_cnt_nxt_s < duty_q_nxt_s);
   end

   // Channel FSM next states and the output values they imply.
   always_comb begin
      ch0_nxt_s = ch_next(ch0_r, cmd_valid(motorEn[0], motorIn[1:0]), motorIn[1:0]);
      ch1_nxt_s = ch_next(ch1_r, cmd_valid(motorEn[1], motorIn[3:2]), motorIn[3:2]);

      hb_in_nxt_s = {leg_drive(ch1_nxt_s), leg_drive(ch0_nxt_s)};
      hb_en_nxt_s = {(ch1_nxt_s.st == ST_RUN) && pwm_on_nxt_s,
                     (ch0_nxt_s.st == ST_RUN) && pwm_on_nxt_s};
      dead_nxt_s  = {(ch1_nxt_s.st == ST_DEAD), (ch0_nxt_s.st == ST_DEAD)};
   end

   // State and output registers; reset aborts any RUN or DEAD interval at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt_r <= {PWM_W{1'b0}};
         duty_q_r  <= {PWM_W{1'b0}};
         ch0_r     <= CH_RESET;
         ch1_r     <= CH_RESET;
         hb_in_r   <= 4'b0000;
         hb_en_r   <= 2'b00;
         dead_r    <= 2'b00;
      end else begin
         pwm_cnt_r <= pwm_cnt_nxt_s;
         duty_q_r  <= duty_q_nxt_s;
         ch0_r     <= ch0_nxt_s;
         ch1_r     <= ch1_nxt_s;
         hb_in_r   <= hb_in_nxt_s;
         hb_en_r   <= hb_en_nxt_s;
         dead_r    <= dead_nxt_s;
      end
   end

   assign hb_in = hb_in_r;
   assign hb_en = hb_en_r;
   assign dead  = dead_r;

endmodule

// File: tb/tb_motor_drive.sv
// Bench for motor_drive (DEAD_CYCLES = 4, PWM_W = 8).
// A vector table covers the channel FSMs; hand-written sequences cover the
// PWM period behaviour and a reversal with PWM active. Expected values are
// queued when stimulus is driven and compared once the DUT has clocked it.
module tb_motor_drive;

   localparam int DEAD_N = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] motorIn;
   logic [1:0] motorEn;
   logic [7:0] duty;
   logic [3:0] hb_in;
   logic [1:0] hb_en;
   logic [1:0] dead;

   always #5 clk = ~clk;

   motor_drive #(.DEAD_CYCLES(DEAD_N), .PWM_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .motorIn (motorIn),
      .motorEn (motorEn),
      .duty    (duty),
      .hb_in   (hb_in),
      .hb_en   (hb_en),
      .dead    (dead)
   );

   typedef struct {
      logic [3:0] hb;
      logic [1:0] en;
      logic [1:0] dd;
      string      name;
   } exp_t;

   typedef struct {
      logic       rst;
      logic [3:0] mi;
      logic [1:0] me;
      logic [3:0] hb;
      logic [1:0] dd;
   } vec_t;

   exp_t       sb_q[$];
   vec_t       vecs[32];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] m_cnt;
   logic [7:0] m_dq;
   int         hi0;
   int         hi1;

   // One clock: drive inputs, model the PWM, queue expectations, compare after the edge.
   task automatic step(input logic r, input logic [3:0] mi, input logic [1:0] me,
                       input logic [7:0] du, input logic [3:0] ehb, input logic [1:0] edd,
                       input string nm);
      exp_t e;
      exp_t got;
      logic on;
      reset   = r;
      motorIn = mi;
      motorEn = me;
      duty    = du;
      @(posedge clk);
      if (r) begin
         m_cnt = 8'd0;
         m_dq  = 8'd0;
      end else begin
         if (m_cnt == 8'hFF) m_dq = du;
         m_cnt = m_cnt + 8'd1;
      end
      on     = (m_cnt < m_dq);
      e.hb   = ehb;
      e.dd   = edd;
      e.en   = {(ehb[3:2] != 2'b00) && on, (ehb[1:0] != 2'b00) && on};
      e.name = nm;
      sb_q.push_back(e);
      @(negedge clk);
      got = sb_q.pop_front();
      checks++;
      if (hb_in !== got.hb) begin
         errors++;
         $display("FAIL %s hb_in: got %b expected %b", got.name, hb_in, got.hb);
      end
      checks++;
      if (hb_en !== got.en) begin
         errors++;
         $display("FAIL %s hb_en: got %b expected %b (pwm cnt %0d duty_q %0d)",
                  got.name, hb_en, got.en, m_cnt, m_dq);
      end
      checks++;
      if (dead !== got.dd) begin
         errors++;
         $display("FAIL %s dead: got %b expected %b", got.name, dead, got.dd);
      end
      hi0 = hi0 + int'(hb_en[0]);
      hi1 = hi1 + int'(hb_en[1]);
   endtask

   task automatic check_int(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   initial begin
      //            rst    motorIn  motorEn  hb_in    dead
      vecs[0]  = '{1'b1, 4'b1010, 2'b11, 4'b0000, 2'b00}; // reset state
      vecs[1]  = '{1'b0, 4'b1010, 2'b11, 4'b1010, 2'b00}; // both OFF->RUN in one edge
      vecs[2]  = '{1'b0, 4'b1010, 2'b11, 4'b1010, 2'b00};
      vecs[3]  = '{1'b0, 4'b0110, 2'b11, 4'b0010, 2'b10}; // ch1 reversal
      vecs[4]  = '{1'b0, 4'b0110, 2'b11, 4'b0010, 2'b10};
      vecs[5]  = '{1'b0, 4'b0110, 2'b11, 4'b0010, 2'b10};
      vecs[6]  = '{1'b0, 4'b0110, 2'b11, 4'b0010, 2'b10};
      vecs[7]  = '{1'b0, 4'b0110, 2'b11, 4'b0110, 2'b00}; // new direction after 4 dead cycles
      vecs[8]  = '{1'b0, 4'b0110, 2'b11, 4'b0110, 2'b00};
      vecs[9]  = '{1'b0, 4'b1010, 2'b11, 4'b0010, 2'b10}; // reverse back
      vecs[10] = '{1'b0, 4'b1010, 2'b01, 4'b0010, 2'b10}; // disable mid-dead
      vecs[11] = '{1'b0, 4'b1010, 2'b01, 4'b0010, 2'b10};
      vecs[12] = '{1'b0, 4'b1010, 2'b01, 4'b0010, 2'b10};
      vecs[13] = '{1'b0, 4'b1010, 2'b01, 4'b0010, 2'b00}; // dead ends disabled -> OFF
      vecs[14] = '{1'b0, 4'b1010, 2'b11, 4'b1010, 2'b00};
      vecs[15] = '{1'b0, 4'b0110, 2'b11, 4'b0010, 2'b10}; // reversal ...
      vecs[16] = '{1'b0, 4'b1010, 2'b11, 4'b0010, 2'b10}; // ... re-reversed mid-dead
      vecs[17] = '{1'b0, 4'b1010, 2'b11, 4'b0010, 2'b10};
      vecs[18] = '{1'b0, 4'b1010, 2'b11, 4'b0010, 2'b10};
      vecs[19] = '{1'b0, 4'b1010, 2'b11, 4'b1010, 2'b00}; // full dead, then RUN 10
      vecs[20] = '{1'b0, 4'b0010, 2'b11, 4'b0010, 2'b00}; // stop: no dead time
      vecs[21] = '{1'b0, 4'b1110, 2'b11, 4'b0010, 2'b00}; // 2'b11 is a stop
      vecs[22] = '{1'b0, 4'b0001, 2'b11, 4'b0000, 2'b01}; // ch0 reversal
      vecs[23] = '{1'b0, 4'b0001, 2'b11, 4'b0000, 2'b01};
      vecs[24] = '{1'b0, 4'b0000, 2'b11, 4'b0000, 2'b01}; // stop mid-dead ignored
      vecs[25] = '{1'b0, 4'b0000, 2'b11, 4'b0000, 2'b01};
      vecs[26] = '{1'b0, 4'b0000, 2'b11, 4'b0000, 2'b00}; // ends stopped -> OFF
      vecs[27] = '{1'b0, 4'b0001, 2'b11, 4'b0001, 2'b00};
      vecs[28] = '{1'b0, 4'b0010, 2'b11, 4'b0000, 2'b01}; // ch0 dead ...
      vecs[29] = '{1'b1, 4'b0010, 2'b11, 4'b0000, 2'b00}; // ... aborted by reset
      vecs[30] = '{1'b0, 4'b0101, 2'b11, 4'b0101, 2'b00}; // RUN with no dead time
      vecs[31] = '{1'b0, 4'b0101, 2'b11, 4'b0101, 2'b00};

      hi0 = 0;
      hi1 = 0;
      for (int i = 0; i < 32; i++) begin
         step(vecs[i].rst, vecs[i].mi, vecs[i].me, 8'd64, vecs[i].hb, vecs[i].dd,
              $sformatf("vec%0d", i));
      end

      // PWM: reset, run both channels; duty 64, raised to 192 at counter 100 of the first period.
      step(1'b1, 4'b1010, 2'b11, 8'd64, 4'b0000, 2'b00, "pwm_reset");
      for (int k = 1; k <= 767; k++) begin
         if (k == 256) begin
            hi0 = 0;
            hi1 = 0;
         end
         if (k == 512) begin
            check_int("pwm_period1_ch0_high", hi0, 64);
            check_int("pwm_period1_ch1_high", hi1, 64);
            hi0 = 0;
            hi1 = 0;
         end
         step(1'b0, 4'b1010, 2'b11, (k >= 357) ? 8'd192 : 8'd64, 4'b1010, 2'b00, "pwm_run");
      end
      check_int("pwm_period2_ch0_high", hi0, 192);
      check_int("pwm_period2_ch1_high", hi1, 192);

      // Reversal with PWM active: ch1 enable held low through dead, ch0 keeps modulating.
      for (int k = 0; k < DEAD_N; k++) begin
         step(1'b0, 4'b0110, 2'b11, 8'd192, 4'b0010, 2'b10, "rev_pwm_dead");
      end
      step(1'b0, 4'b0110, 2'b11, 8'd192, 4'b0110, 2'b00, "rev_pwm_run");
      step(1'b0, 4'b0110, 2'b11, 8'd192, 4'b0110, 2'b00, "rev_pwm_hold");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Bound the whole run in case stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
